// File: rtl/sr_pkg.sv
// Shared definitions for the SR flop bank.
// Contents:
//   SR_MODE_*  conflict-resolution rule selectors for the MODE parameter
//   sr_next()  next-state rule for one channel, given normalised set/reset
package sr_pkg;

    localparam int SR_MODE_SET_DOM = 0;
    localparam int SR_MODE_RST_DOM = 1;
    localparam int SR_MODE_HOLD    = 2;
    localparam int SR_MODE_TOGGLE  = 3;

    // sn/rn are already active-high here; polarity is handled by the caller.
    function automatic logic sr_next(input int mode, input logic q, input logic sn, input logic rn);
        logic nxt;
        nxt = q;
        unique case ({sn, rn})
            2'b10: nxt = 1'b1;
            2'b01: nxt = 1'b0;
            2'b00: nxt = q;
            default: begin
                case (mode)
                    SR_MODE_SET_DOM: nxt = 1'b1;
                    SR_MODE_RST_DOM: nxt = 1'b0;
                    SR_MODE_HOLD:    nxt = q;
                    default:         nxt = ~q;
                endcase
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_flop_bank_if.sv
// Bus bundle for sr_flop_bank.
// Ports (from the bank's point of view):
//   en, s, r, err_clr                      inputs driven by the controller
//   q, qbar, q_rise, q_fall, conflict,
//   err_sticky, err_count                  outputs produced by the bank
interface sr_flop_bank_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
);
    logic                 en;
    logic [WIDTH-1:0]     s;
    logic [WIDTH-1:0]     r;
    logic                 err_clr;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     qbar;
    logic [WIDTH-1:0]     q_rise;
    logic [WIDTH-1:0]     q_fall;
    logic [WIDTH-1:0]     conflict;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output en, s, r, err_clr,
        input  q, qbar, q_rise, q_fall, conflict, err_sticky, err_count
    );

    modport slave (
        input  en, s, r, err_clr,
        output q, qbar, q_rise, q_fall, conflict, err_sticky, err_count
    );
endinterface

// File: rtl/sr_cell.sv
// One SR storage channel.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   en          update enable
//   s, r        set/reset request (polarity per ACTIVE_LOW)
//   hit         combinational en & sn & rn, used by the bank for error accounting
//   q           stored bit
//   q_rise      pulse when q went 0->1 on the last update
//   q_fall      pulse when q went 1->0 on the last update
//   conflict    registered hit
module sr_cell
    import sr_pkg::*;
#(
    parameter int MODE       = SR_MODE_SET_DOM,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic hit,
    output logic q,
    output logic q_rise,
    output logic q_fall,
    output logic conflict
);

    logic sn;
    logic rn;
    logic q_nxt;

    assign sn    = ACTIVE_LOW ? ~s : s;
    assign rn    = ACTIVE_LOW ? ~r : r;
    assign hit   = en & sn & rn;
    assign q_nxt = sr_next(MODE, q, sn, rn);

    // Edge pulses and conflict are only meaningful for an enabled update;
    // a disabled cycle forces them low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= RST_VAL;
            q_rise   <= 1'b0;
            q_fall   <= 1'b0;
            conflict <= 1'b0;
        end else if (en) begin
            q        <= q_nxt;
            q_rise   <= q_nxt & ~q;
            q_fall   <= ~q_nxt & q;
            conflict <= sn & rn;
        end else begin
            q_rise   <= 1'b0;
            q_fall   <= 1'b0;
            conflict <= 1'b0;
        end
    end

endmodule

// File: rtl/sr_flop_bank.sv
// Multi-channel clocked SR flag register with conflict detection.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        sr_flop_bank_if.slave: en, s, r, err_clr in;
//              q, qbar, q_rise, q_fall, conflict, err_sticky, err_count out
// err_count counts cycles with at least one conflicting channel and
// saturates at all-ones; err_clr on a conflict cycle restarts it at 1.
module sr_flop_bank
    import sr_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MODE       = SR_MODE_SET_DOM,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit RST_VAL    = 1'b0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    sr_flop_bank_if.slave     bus
);

    if (MODE < 0 || MODE > 3) begin : g_bad_mode
        $fatal(1, "sr_flop_bank: illegal MODE %0d", MODE);
    end

    logic [WIDTH-1:0] hit;
    logic             any_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE       (MODE),
            .ACTIVE_LOW (ACTIVE_LOW),
            .RST_VAL    (RST_VAL)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .en       (bus.en),
            .s        (bus.s[i]),
            .r        (bus.r[i]),
            .hit      (hit[i]),
            .q        (bus.q[i]),
            .q_rise   (bus.q_rise[i]),
            .q_fall   (bus.q_fall[i]),
            .conflict (bus.conflict[i])
        );
    end

    // qbar is derived from the q register only, so it can never equal q.
    assign bus.qbar = ~bus.q;
    assign any_c    = |hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.err_sticky <= 1'b0;
            bus.err_count  <= '0;
        end else if (bus.err_clr) begin
            // Clear first, then record this cycle's event so none is lost.
            bus.err_sticky <= any_c;
            bus.err_count  <= any_c ? ERR_CNT_W'(1) : '0;
        end else if (any_c) begin
            bus.err_sticky <= 1'b1;
            if (bus.err_count != '1) begin
                bus.err_count <= bus.err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed bench for sr_flop_bank: six instances (modes 0..3, active-low,
// RST_VAL=1) share clock/reset and mostly share stimulus.
module tb_sr_flop_bank;
    import sr_pkg::*;

    localparam int W  = 4;
    localparam int CW = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] s = '0;
    logic [W-1:0] r = '0;
    logic [W-1:0] sal = '1;
    logic [W-1:0] ral = '1;
    logic         err_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sr_flop_bank_if #(.WIDTH(W), .ERR_CNT_W(CW)) b0 ();
    sr_flop_bank_if #(.WIDTH(W), .ERR_CNT_W(CW)) b1 ();
    sr_flop_bank_if #(.WIDTH(W), .ERR_CNT_W(CW)) b2 ();
    sr_flop_bank_if #(.WIDTH(W), .ERR_CNT_W(CW)) b3 ();
    sr_flop_bank_if #(.WIDTH(W), .ERR_CNT_W(CW)) b4 ();
    sr_flop_bank_if #(.WIDTH(W), .ERR_CNT_W(CW)) b5 ();

    assign b0.en = en;  assign b0.s = s;   assign b0.r = r;   assign b0.err_clr = err_clr;
    assign b1.en = en;  assign b1.s = s;   assign b1.r = r;   assign b1.err_clr = err_clr;
    assign b2.en = en;  assign b2.s = s;   assign b2.r = r;   assign b2.err_clr = err_clr;
    assign b3.en = en;  assign b3.s = s;   assign b3.r = r;   assign b3.err_clr = err_clr;
    assign b4.en = en;  assign b4.s = sal; assign b4.r = ral; assign b4.err_clr = err_clr;
    assign b5.en = en;  assign b5.s = s;   assign b5.r = r;   assign b5.err_clr = err_clr;

    sr_flop_bank #(.WIDTH(W), .MODE(0), .ACTIVE_LOW(1'b0), .RST_VAL(1'b0), .ERR_CNT_W(CW))
        u0 (.clk(clk), .rst(rst), .bus(b0));
    sr_flop_bank #(.WIDTH(W), .MODE(1), .ACTIVE_LOW(1'b0), .RST_VAL(1'b0), .ERR_CNT_W(CW))
        u1 (.clk(clk), .rst(rst), .bus(b1));
    sr_flop_bank #(.WIDTH(W), .MODE(2), .ACTIVE_LOW(1'b0), .RST_VAL(1'b0), .ERR_CNT_W(CW))
        u2 (.clk(clk), .rst(rst), .bus(b2));
    sr_flop_bank #(.WIDTH(W), .MODE(3), .ACTIVE_LOW(1'b0), .RST_VAL(1'b0), .ERR_CNT_W(CW))
        u3 (.clk(clk), .rst(rst), .bus(b3));
    sr_flop_bank #(.WIDTH(W), .MODE(0), .ACTIVE_LOW(1'b1), .RST_VAL(1'b0), .ERR_CNT_W(CW))
        u4 (.clk(clk), .rst(rst), .bus(b4));
    sr_flop_bank #(.WIDTH(W), .MODE(0), .ACTIVE_LOW(1'b0), .RST_VAL(1'b1), .ERR_CNT_W(CW))
        u5 (.clk(clk), .rst(rst), .bus(b5));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_q0",      32'(b0.q), 32'h0);
        check("rst_qbar0",   32'(b0.qbar), 32'hF);
        check("rst_cnt0",    32'(b0.err_count), 32'h0);
        check("rst_sticky0", 32'(b0.err_sticky), 32'h0);
        check("rst_q5",      32'(b5.q), 32'hF);
        rst = 1'b0;

        // Basic set/reset
        en = 1'b1; s = 4'b0011; r = 4'b1100;
        step();
        check("basic_q",     32'(b0.q), 32'h3);
        check("basic_qbar",  32'(b0.qbar), 32'hC);
        check("basic_rise",  32'(b0.q_rise), 32'h3);
        check("basic_fall",  32'(b0.q_fall), 32'h0);
        check("basic_q5",    32'(b5.q), 32'h3);
        check("basic_fall5", 32'(b5.q_fall), 32'hC);
        s = '0; r = '0;
        step();
        check("hold_q",      32'(b0.q), 32'h3);
        check("hold_rise",   32'(b0.q_rise), 32'h0);

        // Clear everything, then a single-channel conflict in each mode
        r = 4'hF;
        step();
        check("clr_q0",      32'(b0.q), 32'h0);
        check("clr_fall0",   32'(b0.q_fall), 32'h3);
        s = 4'b0001; r = 4'b0001;
        step();
        check("cf_q_m0",     32'(b0.q), 32'h1);
        check("cf_q_m1",     32'(b1.q), 32'h0);
        check("cf_q_m2",     32'(b2.q), 32'h0);
        check("cf_q_m3",     32'(b3.q), 32'h1);
        check("cf_c_m0",     32'(b0.conflict), 32'h1);
        check("cf_c_m1",     32'(b1.conflict), 32'h1);
        check("cf_c_m2",     32'(b2.conflict), 32'h1);
        check("cf_c_m3",     32'(b3.conflict), 32'h1);
        check("cf_qbar_m0",  32'(b0.qbar), 32'hE);
        check("cf_qbar_m3",  32'(b3.qbar), 32'hE);
        check("cf_cnt1",     32'(b0.err_count), 32'h1);
        check("cf_sticky",   32'(b0.err_sticky), 32'h1);
        step();
        check("toggle_q_m3", 32'(b3.q), 32'h0);
        check("toggle_fall", 32'(b3.q_fall), 32'h1);
        check("cf_cnt2",     32'(b0.err_count), 32'h2);
        for (int i = 0; i < 3; i++) step();
        check("cnt_sat",     32'(b0.err_count), 32'h3);

        // Conflict removed: registered flag drops
        s = '0; r = '0;
        step();
        check("cf_gone",     32'(b0.conflict), 32'h0);
        check("cnt_held",    32'(b0.err_count), 32'h3);

        // Enable gating
        en = 1'b0; s = 4'hF; r = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("en0_q",    32'(b0.q), 32'h1);
            check("en0_rise", 32'(b0.q_rise), 32'h0);
            check("en0_cnt",  32'(b0.err_count), 32'h3);
        end

        // err_clr together with a conflict, then alone
        en = 1'b1; s = 4'b0001; r = 4'b0001; err_clr = 1'b1;
        step();
        check("clr_cf_cnt",    32'(b0.err_count), 32'h1);
        check("clr_cf_sticky", 32'(b0.err_sticky), 32'h1);
        s = '0; r = '0;
        step();
        check("clr_cnt",       32'(b0.err_count), 32'h0);
        check("clr_sticky",    32'(b0.err_sticky), 32'h0);
        err_clr = 1'b0;

        // Active-low instance
        sal = 4'b1110; ral = 4'b1111;
        step();
        check("al_set_q",    32'(b4.q), 32'h1);
        check("al_set_rise", 32'(b4.q_rise), 32'h1);
        sal = 4'hF; ral = 4'hF;
        step();
        check("al_hold_q",   32'(b4.q), 32'h1);
        check("al_hold_c",   32'(b4.conflict), 32'h0);
        sal = 4'hE; ral = 4'hE;
        step();
        check("al_cf_c",     32'(b4.conflict), 32'h1);
        check("al_cf_q",     32'(b4.q), 32'h1);
        sal = 4'hF; ral = 4'hF;

        // Mid-run asynchronous reset
        s = 4'b0101; r = 4'b1011;
        step();
        check("pre_rst_q5",  32'(b5.q), 32'h5);
        check("pre_rst_cnt", 32'(b0.err_count), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_q5",     32'(b5.q), 32'hF);
        check("arst_qbar5",  32'(b5.qbar), 32'h0);
        check("arst_cnt",    32'(b0.err_count), 32'h0);
        check("arst_q0",     32'(b0.q), 32'h0);
        check("arst_c0",     32'(b0.conflict), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
